// File: rtl/param_counter.sv
// param_counter: up/down counter with a prescaler, a programmable upper bound,
// and wrap or saturate behaviour at the bounds. It produces a terminal-count
// pulse (tc) and a sticky overflow flag (ovf).
module param_counter #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf
);

   // The prescaler needs at least one bit, even when PRESCALE is 1.
   localparam int             PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

   logic [PCW-1:0]   pc_q, pc_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             step;

   // Prescaler. A step fires on the enabled cycle where pc reaches PRESCALE-1.
   // An out-of-range pc value keeps incrementing and wraps to 0, so it cannot
   // lock up.
   always_comb begin
      pc_d = pc_q;
      step = 1'b0;
      if (en) begin
         if (pc_q == PC_LAST) begin
            pc_d = '0;
            step = 1'b1;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   // Next-state logic for the count and flags.
   // Priority order is clr, then load, then step, then hold.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (step) begin
         if (dir) begin
            // A loaded value above max_val counts as already at the bound.
            if (cnt_q >= max_val) begin
               cnt_d = (SATURATE != 0) ? max_val : '0;
               tc_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == '0) begin
               cnt_d = (SATURATE != 0) ? '0 : max_val;
               tc_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         if (tc_d) ovf_d = 1'b1;
      end
   end

   // State registers. Clearing or loading also restarts the prescaler, so
   // the next step needs a full PRESCALE enabled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= '0;
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         pc_q  <= (clr || load) ? '0 : pc_d;
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule
